emir_issue_ctrl: RTL
====================

// Module: emir_issue_ctrl
// PURPOSE
// Issue controller and round-robin arbiter that shares one emir_prep -> emir_end
//   operand datapath among NREQ requesters.
// The datapath has a fixed latency and cannot be stalled. This block grants one
//   request per cycle, tags each issue with its requester ID, and captures results
//   into a local result FIFO.
// Issue is credit-limited, so the FIFO never overflows.
// A drain handshake lets the system quiesce the datapath before reconfiguration.
// PARAMETERS
// NREQ   4   number of requesters (>=2)
// IDW    2   requester ID width, = clog2(NREQ)
// W      32  operand/result width (IEEE754 single)
// LAT    3   datapath latency, issue to result, in cycles (>=1)
// DEPTH  4   result FIFO entries (>=2)
// PORTS
// clk        in   1        clock, all state on rising edge
// rst        in   1        synchronous reset, active-high
// req_valid  in   NREQ     per-requester operand valid
// req_ready  out  NREQ     per-requester accept; one-hot or zero
// req_a      in   NREQ*W   operand A, requester i at [i*W +: W]
// req_b      in   NREQ*W   operand B, requester i at [i*W +: W]
// dp_issue   out  1        operands valid into the datapath this cycle
// dp_a       out  W        operand A to datapath (emir_prep A)
// dp_b       out  W        operand B to datapath (emir_prep B)
// dp_z       in   W        datapath result Z; valid exactly LAT cycles after dp_issue
// dp_y       in   1        datapath flag Y; same timing as dp_z
// res_valid  out  1        result FIFO non-empty
// res_ready  in   1        consumer pops the head when res_valid && res_ready
// res_z      out  W        head result Z
// res_y      out  1        head flag Y
// res_id     out  IDW      requester ID of the head result
// drain      in   1        request quiesce; level-sensitive
// drained    out  1        datapath empty, FIFO empty, no issue possible
// busy       out  1        inflight != 0 or FIFO non-empty
// BEHAVIOUR
// - Reset values (sync, rst=1):
//   - FIFO empty, inflight=0, tag pipe cleared, FSM=RUN.
//   - rr_last=NREQ-1, so requester 0 wins first.
//   - Registered outputs read 0: res_valid=0, drained=0, busy=0.
// - Reset mid-operation discards all in-flight and queued results; no res_valid afterwards.
// - Credit rule: issue is allowed only if occ + inflight < DEPTH.
//   - occ is the FIFO count; inflight is the number of valid tag-pipe stages.
// - Arbitration (comb):
//   - Scan i = rr_last+1 .. rr_last+NREQ, mod NREQ.
//   - The first req_valid[i] wins, provided FSM==RUN and credit is available.
//   - req_ready[winner]=1; all other bits 0.
//   - dp_issue=|req_ready; dp_a/dp_b are muxed from the winner.
//   - On issue, rr_last<=winner. With no issue, rr_last holds.
// - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
// - Tag pipe: LAT stages of {v,id}; stage 0 loads {dp_issue, winner id}.
//   - When stage LAT-1 is valid, {dp_z, dp_y, id} is pushed into the FIFO that cycle.
// - FIFO: push and pop in the same cycle are legal at any occupancy.
//   - Pointers wrap modulo DEPTH.
//   - Push while full cannot occur given the credit rule; this is a simulation assertion.
// - res_* outputs show the FIFO head. Data is stable while res_valid && !res_ready.
// - A pop freeing a slot grants credit for an issue in the same cycle; no bubble.
// - FSM:
//   - RUN -> DRAIN when drain=1. Issue stops in the same cycle: req_ready=0.
//   - DRAIN -> IDLE when inflight==0 && occ==0. FIFO pops continue in DRAIN.
//   - IDLE: drained=1 (registered). IDLE -> RUN when drain=0. drained=0 the next cycle.
//   - DRAIN with drain deasserted before empty -> RUN.
// - Throughput: 1 issue/cycle sustained when res_ready=1 and DEPTH >= LAT+1.
//   - Otherwise it is limited by credits.
// TESTING
// 1. Reset, then req_valid=4'b0001 with A=3F800000, B=40000000, one cycle.
//    -> dp_issue at cycle 0.
//    -> res_valid at cycle LAT+1 with res_id=0 and res_z=dp_z model value.
// 2. req_valid=4'b1111 held for 8 cycles, res_ready=1.
//    -> grants 0,1,2,3,0,1,2,3; res_id sequence identical; no idle cycle.
// 3. res_ready=0, req_valid=4'b0010 held.
//    -> exactly DEPTH=4 issues, then req_ready=0.
//    -> Raise res_ready for 1 cycle: one pop and one new issue in the same cycle.
// 4. 2 results in flight and 1 queued, then drain=1.
//    -> no further req_ready.
//    -> drained=1 only after all 3 results have popped. Drop drain -> issue resumes the next cycle.
// 5. rst pulsed while 3 results are in flight.
//    -> res_valid stays 0 for LAT+2 cycles; rr restarts at requester 0.
// 6. Single requester 2 and requester 3 alternating valid, pop and push in the same cycle at occ=DEPTH-1.
//    -> FIFO count stays correct; no overflow assertion.

Source files
------------

// File: rtl/emir_issue_ctrl.sv
// Round-robin issue controller for the shared emir_prep -> emir_end datapath.
// Tags each issue with its requester ID and credit-limits issue into a local result FIFO.
module emir_issue_ctrl #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2,
  parameter int unsigned W     = 32,
  parameter int unsigned LAT   = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              dp_issue,
  output logic [W-1:0]      dp_a,
  output logic [W-1:0]      dp_b,
  input  logic [W-1:0]      dp_z,
  input  logic              dp_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_z,
  output logic              res_y,
  output logic [IDW-1:0]    res_id,
  input  logic              drain,
  output logic              drained,
  output logic              busy
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(LAT + 1);

  typedef enum logic [1:0] {StRun, StDrain, StIdle} state_e;
  state_e state_q, state_d;

  logic [IDW-1:0] rr_q, winner, scan_idx;
  logic           found;
  logic [LAT-1:0] tag_v_q;
  logic [IDW-1:0] tag_id_q [LAT];
  logic [FW-1:0]  inflight;

  logic [W-1:0]   mem_z  [DEPTH];
  logic           mem_y  [DEPTH];
  logic [IDW-1:0] mem_id [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           push, pop, credit_ok, issue_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int s = 0; s < int'(LAT); s++) inflight = inflight + FW'(tag_v_q[s]);
  end

  assign push = tag_v_q[LAT-1];
  assign pop  = (count_q != '0) && res_ready;
  // Results already queued or in flight each hold a slot; a same-cycle pop frees one.
  assign credit_ok = (32'(count_q) + 32'(inflight) - 32'(pop)) < DEPTH;
  assign issue_en  = (state_q == StRun) && !drain && credit_ok;

  always_comb begin
    found    = 1'b0;
    winner   = rr_q;
    scan_idx = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      scan_idx = IDW'((32'(rr_q) + 32'(k)) % NREQ);
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && issue_en) req_ready[winner] = 1'b1;
  end

  assign dp_issue = |req_ready;

  always_comb begin
    dp_a = '0;
    dp_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (winner == IDW'(i)) begin
        dp_a = req_a[i*W +: W];
        dp_b = req_b[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= IDW'(NREQ - 1);
      tag_v_q <= '0;
      for (int s = 0; s < int'(LAT); s++) tag_id_q[s] <= '0;
    end else begin
      if (dp_issue) rr_q <= winner;
      tag_v_q[0]  <= dp_issue;
      tag_id_q[0] <= winner;
      for (int s = 1; s < int'(LAT); s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_z[wr_ptr_q]  <= dp_z;
      mem_y[wr_ptr_q]  <= dp_y;
      mem_id[wr_ptr_q] <= tag_id_q[LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (count_q == CW'(DEPTH))))
        else $error("emir_issue_ctrl: result FIFO overflow");
    end
  end

  assign res_valid = (count_q != '0);
  assign res_z     = mem_z[rd_ptr_q];
  assign res_y     = mem_y[rd_ptr_q];
  assign res_id    = mem_id[rd_ptr_q];
  assign busy      = (inflight != '0) || (count_q != '0);
  assign drained   = (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (drain) state_d = StDrain;
      StDrain: begin
        if (!drain) state_d = StRun;
        else if ((inflight == '0) && (count_q == '0)) state_d = StIdle;
      end
      StIdle:  if (!drain) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

endmodule
